router_fifo: RTL
================

# router_fifo

Per-port output buffer of the 1x3 router. It sits between the router's register/write-control logic and one destination port. It stores bytes written by the router core in a 16-entry FIFO and presents them to the destination agent through the `data_out` / `vld_out` / `read_enb` handshake. Each entry carries a header-marker bit, so the FIFO tracks how many bytes of the current packet remain to be read out.

## Interface
- `DEPTH`, 16: number of entries; power of two.
- `WIDTH`, 8: data byte width.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `soft_reset`  in  1  synchronous flush from the timeout logic; active high.
- `write_enb`  in  1  write request from the router core.
- `lfd_state`  in  1  marks the byte written this cycle as a packet header.
- `data_in`  in  8  byte to write.
- `read_enb`  in  1  read request from the destination agent.
- `data_out`  out  8  byte read out; registered.
- `vld_out`  out  1  FIFO holds at least one entry (`!empty`).
- `full`  out  1  DEPTH entries stored.
- `empty`  out  1  zero entries stored.
- `pkt_active`  out  1  bytes of the current packet remain to be read (`pkt_cnt != 0`).

## Operation
- Storage is `mem[DEPTH]` × 9 bits, holding `{lfd_state, data_in}`.
- Pointers `wr_ptr` and `rd_ptr` are 5 bits: 4 address bits plus 1 wrap bit.
  - `empty = (wr_ptr == rd_ptr)`.
  - `full = (wr_ptr[4] != rd_ptr[4]) && (wr_ptr[3:0] == rd_ptr[3:0])`.
- Write occurs when `write_enb && !full`:
  - `mem[wr_ptr[3:0]] <= {lfd_state, data_in}`.
  - `wr_ptr` increments, wrapping 31→0.
- Read occurs when `read_enb && !empty`:
  - `data_out <= mem[rd_ptr[3:0]][7:0]`.
  - `rd_ptr` increments, wrapping 31→0.
- Packet counter `pkt_cnt` is 7 bits, updated on a read only:
  - Entry marker = 1 (header): `pkt_cnt <= mem[..][7:2] + 1`. This counts payload bytes plus parity; the header itself is not counted.
  - Entry marker = 0 and `pkt_cnt != 0`: `pkt_cnt <= pkt_cnt - 1`.
  - Entry marker = 0 and `pkt_cnt == 0`: no change.
- Reads of a non-marker entry outside a packet are still delivered on `data_out`.
- `data_out` holds its last value when no read occurs.
- Write when full is dropped; contents and `wr_ptr` are unchanged.
- Read when empty is ignored; `data_out`, `rd_ptr` and `pkt_cnt` are unchanged.
- Simultaneous read and write, neither blocked: both occur and occupancy is unchanged.
- Simultaneous read and write when full: the read occurs and the write is dropped. Fullness is evaluated before the read.
- Simultaneous read and write when empty: the write occurs and the read is ignored. There is no bypass.
- Priority, highest first: `resetn` low, then `soft_reset`, then normal operation.

## Timing
- Asynchronous reset (`resetn` = 0), effective immediately regardless of `clock`:
  - `wr_ptr = 0`, `rd_ptr = 0`, `pkt_cnt = 0`, `data_out = 8'h00`.
  - `empty = 1`, `full = 0`, `vld_out = 0`, `pkt_active = 0`.
  - `mem` contents need not be cleared.
- `soft_reset` = 1 at a rising edge:
  - Same register values as reset at that edge.
  - Any `write_enb` or `read_enb` in that cycle is discarded.
- Read latency is 1 cycle. With `read_enb` = 1 and `empty` = 0 at edge N, the byte is on `data_out` after edge N.
- `empty`, `full`, `vld_out` and `pkt_active` are combinational from registered pointers and counter. They update in the cycle after the causing edge.
- Write-to-visible latency is 1 cycle. A write at edge N on an empty FIFO makes `vld_out` = 1 after edge N, and the first read can occur at edge N+1.
- The destination samples `vld_out` and drives `read_enb` with 1-unit skew around the posedge. The FIFO does not depend on `read_enb` arriving in the same cycle as `vld_out`.
- Throughput is one write and one read per cycle sustained.

## Test plan
- Reset then one packet:
  - Stimulus: write header `8'h0C` (`lfd_state` = 1, length 3), payload `11`, `22`, `33`, parity `5A`; then assert `read_enb` continuously.
  - Response: `data_out` shows `0C`, `11`, `22`, `33`, `5A` on consecutive cycles.
  - `pkt_cnt` goes 4→3→2→1→0; `pkt_active` drops after the `5A` read.
  - `vld_out` drops after the 5th read.
- Fill and overflow:
  - Stimulus: 17 writes of `8'h00`…`8'h10` with no reads.
  - Response: `full` = 1 after the 16th write; byte `10` is dropped.
  - 16 reads return `00`…`0F`; `empty` = 1 afterward.
- Wrap-around: 40 interleaved writes and reads over many cycles with random occupancy. Every byte is read in order, and no spurious `full`/`empty` occurs across the pointer wrap.
- Boundary simultaneity:
  - At full, read+write in the same cycle: the write is dropped and occupancy becomes 15.
  - At empty, read+write: the write is stored, `data_out` is unchanged, and occupancy becomes 1.
- `soft_reset` mid-packet:
  - Stimulus: after reading a header `8'h14` and 2 payload bytes, pulse `soft_reset`.
  - Response: `empty` = 1, `pkt_active` = 0, `data_out` = `00`.
  - A following new packet reads out correctly.
- Asynchronous reset mid-operation: drop `resetn` between edges while reads and writes are active. All outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/router_fifo.sv
// router_fifo
//   Per-port output buffer of the 1x3 router. Bytes written by the router
//   core are stored with a header-marker bit. The destination agent drains
//   them through the data_out / vld_out / read_enb handshake. A packet
//   counter loaded from the header's length field tracks how many bytes of
//   the current packet (payload plus parity) remain to be read out.
//
// Ports
//   clock       sole clock, rising edge
//   resetn      asynchronous active-low reset
//   soft_reset  synchronous flush, active high; outranks read and write
//   write_enb   write request; dropped when full
//   lfd_state   marks the byte written this cycle as a packet header
//   data_in     byte to write
//   read_enb    read request; ignored when empty
//   data_out    registered read data; holds its value between reads
//   vld_out     at least one entry stored
//   full        DEPTH entries stored
//   empty       no entries stored
//   pkt_active  bytes of the current packet remain to be read
module router_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             vld_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_active
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    // Header length field is data[WIDTH-1:2]; length + 1 needs one extra bit.
    localparam int unsigned CW = WIDTH - 1;

    logic [WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    pkt_cnt;
    logic [WIDTH:0]   rd_entry;
    logic             do_write;
    logic             do_read;

    // Extra wrap bit distinguishes full from empty when addresses coincide.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign vld_out    = !empty;
    assign pkt_active = (pkt_cnt != '0);

    // Both qualifiers use pre-edge occupancy: at full a read still happens
    // while the concurrent write is dropped; at empty there is no bypass.
    assign do_write = write_enb && !full;
    assign do_read  = read_enb && !empty;
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_write && !soft_reset) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
        end else if (do_write) begin
            wr_ptr <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            data_out <= '0;
        end else if (soft_reset) begin
            rd_ptr   <= '0;
            data_out <= '0;
        end else if (do_read) begin
            rd_ptr   <= rd_ptr + PW'(1);
            data_out <= rd_entry[WIDTH-1:0];
        end
    end

    // Header read loads payload length + 1 (parity); the header itself is
    // not counted. Non-header reads outside a packet leave the count at 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt <= '0;
        end else if (soft_reset) begin
            pkt_cnt <= '0;
        end else if (do_read) begin
            if (rd_entry[WIDTH]) begin
                pkt_cnt <= CW'(rd_entry[WIDTH-1:2]) + CW'(1);
            end else if (pkt_cnt != '0) begin
                pkt_cnt <= pkt_cnt - CW'(1);
            end
        end
    end

endmodule
